// File: rtl/demod_responder.sv
// Synchronous demodulator responder: discards SettleSamples valid ADC samples,
// then sums NumSamples samples multiplied by the +/-1 excitation reference and
// presents the signed sum with a level handshake on DemodEn/DemodReady.
//
// state  | meaning
// IDLE   | waiting for DemodEn; clears accumulator and counter on request
// SETTLE | discarding settling samples
// ACCUM  | accumulating reference-weighted samples
// DONE   | result valid, held until DemodEn drops
module demod_responder #(
  parameter int NumSamples    = 1024,
  parameter int SettleSamples = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        DemodEn,
  input  logic [13:0] ADCData,
  input  logic        ADCValid,
  input  logic        RefSign,
  output logic        DemodReady,
  output logic [31:0] DemodResult,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;

  localparam logic [16:0] AccumLast  = 17'(NumSamples - 1);
  // SETTLE is never entered when SettleSamples is 0, so the value is unused then.
  localparam logic [16:0] SettleLast = (SettleSamples > 0) ? 17'(SettleSamples - 1) : 17'd0;

  state_t             state, state_next;
  logic [16:0]        count;
  logic signed [31:0] acc;
  logic signed [31:0] sample;
  logic signed [31:0] sum;
  logic               settle_done;
  logic               accum_done;

  // Sign-extend the sample and apply the reference; 32-bit negation keeps -8192 -> +8192.
  always_comb begin
    sample      = {{18{ADCData[13]}}, ADCData};
    sum         = RefSign ? (acc + sample) : (acc - sample);
    settle_done = ADCValid && (count == SettleLast);
    accum_done  = ADCValid && (count == AccumLast);
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; dropping DemodEn aborts any active run.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (DemodEn) state_next = (SettleSamples > 0) ? SETTLE : ACCUM;
      SETTLE:  if (!DemodEn) state_next = IDLE;
               else if (settle_done) state_next = ACCUM;
      ACCUM:   if (!DemodEn) state_next = IDLE;
               else if (accum_done) state_next = DONE;
      DONE:    if (!DemodEn) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state == SETTLE) || (state == ACCUM);

  // Counter, accumulator and result/handshake registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count       <= '0;
      acc         <= '0;
      DemodResult <= '0;
      DemodReady  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DemodEn) begin
            count <= '0;
            acc   <= '0;
          end
        end
        SETTLE: begin
          if (DemodEn && ADCValid) count <= settle_done ? 17'd0 : count + 17'd1;
        end
        ACCUM: begin
          if (DemodEn && ADCValid) begin
            if (accum_done) begin
              DemodResult <= sum;
              DemodReady  <= 1'b1;
            end else begin
              acc   <= sum;
              count <= count + 17'd1;
            end
          end
        end
        DONE: begin
          if (!DemodEn) DemodReady <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_demod_responder.sv
// Bench for demod_responder (NumSamples=4, SettleSamples=2, plus a SettleSamples=0 build).
module tb_demod_responder;

  localparam int N = 4;
  localparam int S = 2;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        DemodEn = 1'b0;
  logic        DemodEn0 = 1'b0;
  logic [13:0] ADCData = '0;
  logic        ADCValid = 1'b0;
  logic        RefSign = 1'b0;
  logic        DemodReady, DemodReady0;
  logic [31:0] DemodResult, DemodResult0;
  logic        Busy, Busy0;

  int errors = 0;
  int checks = 0;

  demod_responder #(.NumSamples(N), .SettleSamples(S)) dut (
    .Clk(Clk), .Rst(Rst), .DemodEn(DemodEn), .ADCData(ADCData), .ADCValid(ADCValid),
    .RefSign(RefSign), .DemodReady(DemodReady), .DemodResult(DemodResult), .Busy(Busy)
  );

  demod_responder #(.NumSamples(N), .SettleSamples(0)) dut0 (
    .Clk(Clk), .Rst(Rst), .DemodEn(DemodEn0), .ADCData(ADCData), .ADCValid(ADCValid),
    .RefSign(RefSign), .DemodReady(DemodReady0), .DemodResult(DemodResult0), .Busy(Busy0)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full request. dmode: 0 ref=-1 data=d, 1 ref=+1 data=d,
  // 2 alternating ref with data=ref?d:-d, 3 random data and ref.
  // vper: 0 random valid, otherwise valid every vper-th cycle.
  // Reference: the first S valid samples after the request edge are dropped,
  // the next N are summed with the sign chosen by RefSign.
  task automatic run(input int dmode, input int d, input int vper, input string tag);
    int  consumed, guard, v, exp_sum;
    bit  alt;
    DemodEn  = 1'b1;
    ADCValid = 1'b1;
    ADCData  = 14'($urandom);
    RefSign  = 1'($urandom);
    tick();
    chk({tag, "_start_busy"}, 32'(Busy), 32'd1);
    chk({tag, "_start_ready"}, 32'(DemodReady), 32'd0);
    consumed = 0; exp_sum = 0; guard = 0; alt = 1'b1;
    while (consumed < S + N && guard < 200) begin
      ADCValid = (vper == 0) ? 1'($urandom % 2) : ((guard % vper) == 0);
      case (dmode)
        0: begin RefSign = 1'b0; ADCData = 14'(d); end
        1: begin RefSign = 1'b1; ADCData = 14'(d); end
        2: begin RefSign = alt; ADCData = alt ? 14'(d) : 14'(-d); end
        default: begin RefSign = 1'($urandom); ADCData = 14'($urandom); end
      endcase
      if (ADCValid) begin
        consumed++;
        if (consumed > S) begin
          v = $signed(ADCData);
          exp_sum += RefSign ? v : -v;
        end
        alt = !alt;
      end
      tick();
      guard++;
      if (consumed < S + N) begin
        chk({tag, "_busy"}, 32'(Busy), 32'd1);
        chk({tag, "_ready_early"}, 32'(DemodReady), 32'd0);
      end
    end
    ADCValid = 1'b0;
    chk({tag, "_ready"}, 32'(DemodReady), 32'd1);
    chk({tag, "_result"}, DemodResult, 32'(exp_sum));
    chk({tag, "_done_busy"}, 32'(Busy), 32'd0);
  endtask

  task automatic drop(input string tag);
    DemodEn = 1'b0;
    tick();
    chk({tag, "_drop_ready"}, 32'(DemodReady), 32'd0);
    chk({tag, "_drop_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    chk("rst_ready", 32'(DemodReady), 32'd0);
    chk("rst_result", DemodResult, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    tick();
    chk("idle_busy", 32'(Busy), 32'd0);

    run(1, 100, 1, "basic");
    chk("basic_400", DemodResult, 32'd400);
    ADCValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ADCData = 14'($urandom);
      RefSign = 1'($urandom);
      tick();
      chk("hold_ready", 32'(DemodReady), 32'd1);
      chk("hold_result", DemodResult, 32'd400);
      chk("hold_busy", 32'(Busy), 32'd0);
    end
    ADCValid = 1'b0;
    drop("hold");
    chk("hold_after_result", DemodResult, 32'd400);

    run(2, 50, 1, "alt");
    chk("alt_200", DemodResult, 32'd200);
    drop("alt");
    run(0, -8192, 1, "negmin");
    chk("negmin_32768", DemodResult, 32'd32768);
    drop("negmin");
    run(1, -8192, 1, "posmin");
    chk("posmin_const", DemodResult, 32'hFFFF8000);
    drop("posmin");

    run(1, 100, 3, "sparse");
    chk("sparse_400", DemodResult, 32'd400);
    drop("sparse");

    DemodEn = 1'b1; ADCValid = 1'b1; ADCData = 14'd100; RefSign = 1'b1;
    for (int i = 0; i < 1 + S + 2; i++) tick();
    chk("abort_pre_busy", 32'(Busy), 32'd1);
    DemodEn = 1'b0;
    tick();
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_ready", 32'(DemodReady), 32'd0);
    chk("abort_result", DemodResult, 32'd400);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_idle_ready", 32'(DemodReady), 32'd0);
    end
    ADCValid = 1'b0;
    run(1, 10, 1, "fresh");
    chk("fresh_40", DemodResult, 32'd40);
    drop("fresh");

    for (int k = 0; k < 4; k++) begin
      run(3, 0, 0, "rand");
      drop("rand");
    end

    DemodEn = 1'b1; ADCValid = 1'b1; ADCData = 14'd77; RefSign = 1'b1;
    for (int i = 0; i < 1 + S + 1; i++) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("rst_mid_ready", 32'(DemodReady), 32'd0);
    chk("rst_mid_result", DemodResult, 32'd0);
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    run(1, 5, 1, "restart");
    chk("restart_20", DemodResult, 32'd20);
    drop("restart");

    DemodEn0 = 1'b1; ADCValid = 1'b1; ADCData = 14'd7; RefSign = 1'b1;
    tick();
    chk("s0_busy", 32'(Busy0), 32'd1);
    for (int i = 0; i < N - 1; i++) tick();
    chk("s0_ready_early", 32'(DemodReady0), 32'd0);
    tick();
    chk("s0_ready", 32'(DemodReady0), 32'd1);
    chk("s0_result", DemodResult0, 32'd28);
    chk("s0_done_busy", 32'(Busy0), 32'd0);
    DemodEn0 = 1'b0;
    ADCValid = 1'b0;
    tick();
    chk("s0_drop_ready", 32'(DemodReady0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
